// File: rtl/prod_accum.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : prod_accum
// Purpose  : Signed accumulator placed after the registered 8x8 signed
//            multiplier. It sums each group of N_TERMS products into one wide
//            result and presents that result on a valid/ready handshake,
//            together with a sticky overflow flag for the group.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            clr        - synchronous clear of the partial sum (not the result)
//            in_valid   - in_prod carries a product this cycle
//            in_prod    - signed product, PROD_W bits
//            in_ready   - stage accepts a product (state decode only)
//            out_valid  - out_sum / out_ovf hold a finished group
//            out_ready  - downstream takes the result
//            out_sum    - signed group sum, ACC_W bits
//            out_ovf    - at least one add in the group overflowed
// Config   : SATURATE_EN defined   -> each overflowing add clamps to the
//                                     signed ACC_W limit
//            SATURATE_EN undefined -> two's-complement wrap
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module prod_accum #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int               CNT_W  = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_raw;
    logic [ACC_W-1:0]   w_sum;
    logic               w_add_ovf;
    logic               w_accept;
    logic               w_last;

    assign in_ready = (r_state == ST_ACCUM);
    // clr wins over a concurrent product: that product is dropped.
    assign w_accept = in_valid && in_ready && !clr;
    assign w_last   = w_accept && (r_cnt == C_LAST);

    assign w_prod_ext = ACC_W'($signed(in_prod));
    assign w_raw      = r_acc + w_prod_ext;
    // Overflow: operands share a sign that the truncated result does not.
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_raw[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // On overflow the operand sign tells the direction of the clamp.
    assign w_sum = w_add_ovf ? (r_acc[ACC_W-1] ? C_MIN : C_MAX) : w_raw;
`else
    assign w_sum = w_raw;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; clr never changes state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_last)    w_state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_next = ST_ACCUM;
            default:                 w_state_next = ST_ACCUM;
        endcase
    end

    // Partial-sum datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr || w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_add_ovf;
        end
    end

    // Result register; untouched by clr so a pending result survives it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (w_last) begin
            out_valid <= 1'b1;
            out_sum   <= w_sum;
            out_ovf   <= r_ovf | w_add_ovf;
        end else if ((r_state == ST_HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/prod_accum.md
# prod_accum

Signed accumulator stage downstream of the registered 8x8 signed multiplier. It consumes a stream of 16-bit two's-complement products and sums each group of N_TERMS products into one wide result (a dot-product / FIR tap sum). It presents each result on a valid/ready output handshake and flags overflow. Wrap or saturate arithmetic is selected at compile time.

## Interface
- PROD_W, default 16: product width; must equal upstream multiplier output width.
- ACC_W, default 24: accumulator and result width; must satisfy ACC_W >= PROD_W.
- N_TERMS, default 8: products per result; must satisfy N_TERMS >= 1.
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous clear of the partial sum.
- in_valid, input, 1: in_prod is valid this cycle.
- in_prod, input, PROD_W: signed product.
- in_ready, output, 1: stage accepts a product this cycle.
- out_valid, output, 1: out_sum and out_ovf are valid.
- out_ready, input, 1: downstream accepts the result.
- out_sum, output, ACC_W: signed group sum.
- out_ovf, output, 1: overflow occurred within this group.

## Operation
- State is ACCUM or HOLD. Internal registers: acc (ACC_W bits, signed), cnt ($clog2(N_TERMS+1) bits), ovf (sticky).
- in_ready = (state == ACCUM). It is a registered-state decode; in_ready never depends on out_ready.
- Accept = in_valid && in_ready && !clr.
- On accept: sum = acc + sign_extend(in_prod, ACC_W). acc <= sum. cnt <= cnt+1. ovf <= ovf | this add overflowed.
- Final term (accept with cnt == N_TERMS-1):
  - out_sum <= sum; out_ovf <= ovf | this add overflowed; out_valid <= 1.
  - acc, cnt and ovf <= 0; state <= HOLD.
- HOLD:
  - Inputs are ignored.
  - out_sum and out_ovf are held stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0; state <= ACCUM.
- clr, in any state: acc, cnt and ovf <= 0. A product presented in the same cycle is discarded. clr does not affect a pending result: out_valid, out_sum, out_ovf and state are unchanged.
- Overflow of one add: the sign bits of both operands are equal and differ from the sign bit of the exact ACC_W result.
- in_valid while in_ready = 0 is legal; the product is not consumed, and upstream must hold it.

## Timing
- Reset values: state ACCUM; acc, cnt and ovf 0; in_ready 1; out_valid 0; out_sum 0; out_ovf 0.
- Latency: out_valid rises on the clock edge after the final product is accepted.
- Throughput: at most one result per N_TERMS+1 cycles. in_ready is low for at least one cycle per group, and for longer while out_ready stays low.
- After the out_ready handshake edge, in_ready is 1 in the next cycle.
- reset_n asserted mid-group or during HOLD: all registers return to reset values immediately. The partial sum and any pending result are lost.
- N_TERMS = 1: every accepted product goes directly to HOLD.

## Configuration
- SATURATE_EN defined:
  - Each add that overflows clamps to 2^(ACC_W-1)-1 on positive overflow, or -2^(ACC_W-1) on negative overflow.
  - Later adds continue from the clamped value.
  - out_ovf is set when any clamp occurred.
- SATURATE_EN undefined:
  - Two's-complement wrap modulo 2^ACC_W.
  - out_ovf is set when any add wrapped.

## Test plan
- Defaults, 8 products of 16384 (-128 × -128) -> out_sum = 131072, out_ovf = 0, out_valid one cycle after the 8th accept.
- Defaults, products 100, -200, 300, -400, 500, -600, 700, -800 with out_ready held low 5 cycles -> out_sum = -400, held stable. in_ready = 0 throughout HOLD. Next group accepted the cycle after the handshake.
- ACC_W = 16, N_TERMS = 4, four products of 16384 -> SATURATE_EN: out_sum = 32767, out_ovf = 1. Without: out_sum = 0, out_ovf = 1.
- Defaults, 3 products of 1000, then clr together with in_valid (product 5), then 8 products of 1 -> out_sum = 8. The concurrent product is discarded.
- Defaults, reset_n pulsed low after 5 products, then 8 products of -3 -> out_sum = -24. All outputs are at reset values while reset_n is low.
- Defaults, in_valid toggling randomly with out_ready tied high over 10 groups of product 7 -> every out_sum = 56, and no product is lost or double-counted.
